alu_arbiter: RTL and testbench

- Shares the single ECPU ALU instance between NUM_REQ requesters (fetch/address unit, execute unit, debug port, …).
- Accepts one operation at a time using round-robin arbitration and latches its operands into ALU input registers.
- Captures the ALU result and flags into output registers, then returns them to the winning requester with a one-cycle response strobe.
- Sits between the decode/execute logic and the ALU; it is the only driver of the ALU operand, operation and carry inputs.

---
 rtl/alu_arbiter_pkg.sv | 36 +++
 rtl/alu_arbiter_rr_pick.sv | 63 ++++++
 rtl/ecpu_alu.sv | 62 ++++++
 rtl/alu_arbiter.sv | 149 ++++++++++++++
 tb/tb_alu_arbiter.sv | 304 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
// Holds the arbiter FSM state encodings, the default requester count,
// the ALU operation codes and flag bit positions, and a helper that
// sizes requester index fields.
package alu_arbiter_pkg;

  // Arbiter FSM states (2-bit encoding).
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_EXEC = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  // Default number of requesters sharing the ALU.
  localparam int ARB_NUM_REQ = 4;

  // ALU operation codes. Any other code yields a zero result.
  localparam int ALU_ADD = 0;
  localparam int ALU_SUB = 1;  // a + ~b + cin (cin=1 means no borrow)
  localparam int ALU_AND = 2;
  localparam int ALU_OR  = 3;
  localparam int ALU_XOR = 4;

  // ALU flag bit positions.
  localparam int ALU_FLAG_ZERO     = 0;
  localparam int ALU_FLAG_CARRY    = 1;
  localparam int ALU_FLAG_NEGATIVE = 2;
  localparam int ALU_FLAG_OVERFLOW = 3;
  localparam int ALU_FLAG_COUNT    = 4;

  // Width of an index into n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_pick.sv
// Combinational round-robin priority picker.
// Scans the request vector starting at ptr and wrapping modulo NUM_REQ;
// the first set bit wins.
// Ports:
//   req   - request vector, one bit per requester
//   ptr   - index where the scan starts (highest priority)
//   grant - one-hot grant (all zero when nothing is requested)
//   idx   - binary index of the granted requester
//   any   - high when some request is set
module alu_arbiter_rr_pick
  import alu_arbiter_pkg::*;
#(
  parameter int NUM_REQ = ARB_NUM_REQ,
  parameter int IDX_W   = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  localparam int SUM_W = IDX_W + 1;

  logic [SUM_W-1:0] rot_sum [NUM_REQ];
  logic [IDX_W-1:0] rot_idx [NUM_REQ];
  logic [NUM_REQ-1:0] rot_req;
  logic             found;
  logic [IDX_W-1:0] pick;

  // Position gi of the rotated view corresponds to requester (ptr+gi) mod N.
  // The wrap is a single conditional subtract since ptr < NUM_REQ.
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
      assign rot_sum[gi] = {1'b0, ptr} + SUM_W'(gi);
      assign rot_idx[gi] = (rot_sum[gi] >= SUM_W'(NUM_REQ)) ?
                           IDX_W'(rot_sum[gi] - SUM_W'(NUM_REQ)) :
                           IDX_W'(rot_sum[gi]);
      assign rot_req[gi] = req[rot_idx[gi]];
    end
  endgenerate

  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot_req[k]) begin
        found = 1'b1;
        pick  = rot_idx[k];
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_grant
      assign grant[gi] = found && (pick == IDX_W'(gi));
    end
  endgenerate

  assign idx = pick;
  assign any = found;

endmodule

// File: rtl/ecpu_alu.sv
// ECPU combinational ALU.
// Ports:
//   op     - operation code (see alu_arbiter_pkg)
//   a, b   - operands
//   cin    - carry-in (ADD: added in; SUB: 1 = no borrow)
//   result - operation result
//   flags  - zero / carry / negative / overflow
module ecpu_alu
  import alu_arbiter_pkg::*;
#(
  parameter int BUS_SIZE = 32,
  parameter int OP_WIDTH = 8
) (
  input  logic [OP_WIDTH-1:0]       op,
  input  logic [BUS_SIZE-1:0]       a,
  input  logic [BUS_SIZE-1:0]       b,
  input  logic                      cin,
  output logic [BUS_SIZE-1:0]       result,
  output logic [ALU_FLAG_COUNT-1:0] flags
);

  localparam int MSB = BUS_SIZE - 1;

  logic [BUS_SIZE:0] wide;
  logic              carry;
  logic              ovf;

  always_comb begin
    wide   = '0;
    result = '0;
    carry  = 1'b0;
    ovf    = 1'b0;
    case (op)
      OP_WIDTH'(ALU_ADD): begin
        wide   = {1'b0, a} + {1'b0, b} + {{BUS_SIZE{1'b0}}, cin};
        result = wide[MSB:0];
        carry  = wide[BUS_SIZE];
        // Same-sign operands producing an opposite-sign result.
        ovf    = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_WIDTH'(ALU_SUB): begin
        wide   = {1'b0, a} + {1'b0, ~b} + {{BUS_SIZE{1'b0}}, cin};
        result = wide[MSB:0];
        carry  = wide[BUS_SIZE];
        ovf    = (a[MSB] != b[MSB]) && (result[MSB] != a[MSB]);
      end
      OP_WIDTH'(ALU_AND): result = a & b;
      OP_WIDTH'(ALU_OR):  result = a | b;
      OP_WIDTH'(ALU_XOR): result = a ^ b;
      default:            result = '0;
    endcase
  end

  always_comb begin
    flags                    = '0;
    flags[ALU_FLAG_ZERO]     = (result == '0);
    flags[ALU_FLAG_CARRY]    = carry;
    flags[ALU_FLAG_NEGATIVE] = result[MSB];
    flags[ALU_FLAG_OVERFLOW] = ovf;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ECPU ALU between NUM_REQ requesters.
// One operation is accepted in IDLE, evaluated in EXEC and returned in
// RESP, giving one op per three cycles at best.
// Ports:
//   clk, rst_n  - clock and synchronous active-low reset
//   req_valid   - per-requester request
//   req_ready   - one-hot accept strobe (combinational, IDLE only)
//   req_op/a/b  - packed per-requester op code and operands (slice i)
//   req_cin     - per-requester carry-in
//   rsp_valid   - one-hot completion strobe, one cycle, to the owner
//   rsp_result  - registered result of the last completed op
//   rsp_flags   - registered flags of the last completed op
//   busy        - high while an op is in EXEC or RESP
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int BUS_SIZE = 32,
  parameter int NUM_REQ  = ARB_NUM_REQ,
  parameter int OP_WIDTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*OP_WIDTH-1:0]   req_op,
  input  logic [NUM_REQ*BUS_SIZE-1:0]   req_a,
  input  logic [NUM_REQ*BUS_SIZE-1:0]   req_b,
  input  logic [NUM_REQ-1:0]            req_cin,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [BUS_SIZE-1:0]           rsp_result,
  output logic [ALU_FLAG_COUNT-1:0]     rsp_flags,
  output logic                          busy
);

  localparam int IDX_W = idx_width(NUM_REQ);

  arb_state_t state_reg, state_next;
  logic [IDX_W-1:0]          ptr_reg;
  logic [IDX_W-1:0]          owner_reg;
  logic [OP_WIDTH-1:0]       op_reg;
  logic [BUS_SIZE-1:0]       a_reg;
  logic [BUS_SIZE-1:0]       b_reg;
  logic                      cin_reg;
  logic [BUS_SIZE-1:0]       result_reg;
  logic [ALU_FLAG_COUNT-1:0] flags_reg;

  logic [OP_WIDTH-1:0] op_arr [NUM_REQ];
  logic [BUS_SIZE-1:0] a_arr  [NUM_REQ];
  logic [BUS_SIZE-1:0] b_arr  [NUM_REQ];

  logic [NUM_REQ-1:0]        pick_grant;
  logic [IDX_W-1:0]          pick_idx;
  logic                      pick_any;
  logic [BUS_SIZE-1:0]       alu_result;
  logic [ALU_FLAG_COUNT-1:0] alu_flags;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign op_arr[gi] = req_op[gi*OP_WIDTH +: OP_WIDTH];
      assign a_arr[gi]  = req_a[gi*BUS_SIZE +: BUS_SIZE];
      assign b_arr[gi]  = req_b[gi*BUS_SIZE +: BUS_SIZE];
    end
  endgenerate

  alu_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req   (req_valid),
    .ptr   (ptr_reg),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // The ALU only ever sees the latched operands, so requesters are free
  // to change their inputs once they have been accepted.
  ecpu_alu #(
    .BUS_SIZE (BUS_SIZE),
    .OP_WIDTH (OP_WIDTH)
  ) u_alu (
    .op     (op_reg),
    .a      (a_reg),
    .b      (b_reg),
    .cin    (cin_reg),
    .result (alu_result),
    .flags  (alu_flags)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ARB_IDLE: if (pick_any) state_next = ARB_EXEC;
      ARB_EXEC: state_next = ARB_RESP;
      ARB_RESP: state_next = ARB_IDLE;
      default:  state_next = ARB_IDLE;
    endcase
  end

  // Gated by rst_n so nothing is accepted while reset is held.
  assign req_ready = (rst_n && (state_reg == ARB_IDLE)) ? pick_grant : '0;

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rsp
      assign rsp_valid[gi] = (state_reg == ARB_RESP) && (owner_reg == IDX_W'(gi));
    end
  endgenerate

  assign busy       = (state_reg != ARB_IDLE);
  assign rsp_result = result_reg;
  assign rsp_flags  = flags_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg  <= ARB_IDLE;
      ptr_reg    <= '0;
      owner_reg  <= '0;
      op_reg     <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
      cin_reg    <= 1'b0;
      result_reg <= '0;
      flags_reg  <= '0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ARB_IDLE: begin
          if (pick_any) begin
            owner_reg <= pick_idx;
            op_reg    <= op_arr[pick_idx];
            a_reg     <= a_arr[pick_idx];
            b_reg     <= b_arr[pick_idx];
            cin_reg   <= req_cin[pick_idx];
          end
        end
        ARB_EXEC: begin
          result_reg <= alu_result;
          flags_reg  <= alu_flags;
        end
        ARB_RESP: begin
          // Rotating only on completion bounds every requester's wait.
          ptr_reg <= (owner_reg == IDX_W'(NUM_REQ - 1)) ? '0 : owner_reg + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter (4 requesters, 32-bit ALU).
// A transaction-level model tracks which requester should win, when its
// response is due and what the ALU should return (computed with plain
// 64-bit arithmetic); DUT outputs are compared every cycle.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  localparam int N  = 4;
  localparam int BW = 32;
  localparam int OW = 8;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    v;
  logic [N-1:0]    req_ready;
  logic [N*OW-1:0] req_op;
  logic [N*BW-1:0] req_a;
  logic [N*BW-1:0] req_b;
  logic [N-1:0]    req_cin;
  logic [N-1:0]    rsp_valid;
  logic [BW-1:0]   rsp_result;
  logic [ALU_FLAG_COUNT-1:0] rsp_flags;
  logic            busy;

  logic [OW-1:0] t_op [N];
  logic [BW-1:0] t_a  [N];
  logic [BW-1:0] t_b  [N];

  always #5 clk = ~clk;

  always_comb begin
    req_op = '0;
    req_a  = '0;
    req_b  = '0;
    for (int i = 0; i < N; i++) begin
      req_op[i*OW +: OW] = t_op[i];
      req_a[i*BW +: BW]  = t_a[i];
      req_b[i*BW +: BW]  = t_b[i];
    end
  end

  alu_arbiter #(.BUS_SIZE(BW), .NUM_REQ(N), .OP_WIDTH(OW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (v),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_cin    (req_cin),
    .rsp_valid  (rsp_valid),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .busy       (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Model: age -1 = idle, 1 = cycle after accept, 2 = response cycle.
  int            m_age = -1;
  int            m_ptr = 0;
  int            m_owner = 0;
  int            m_granted = -1;
  logic [BW-1:0] m_res = '0, m_pend_res;
  logic [3:0]    m_flags = '0, m_pend_flags;
  logic [OW-1:0] m_op;
  logic [BW-1:0] m_a, m_b;
  logic          m_cin;
  int            grant_log[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [N-1:0] vv, input int p);
    for (int k = 0; k < N; k++) begin
      if (vv[(p + k) % N]) return (p + k) % N;
    end
    return -1;
  endfunction

  function automatic void alu_ref(input logic [OW-1:0] op, input logic [BW-1:0] a,
                                  input logic [BW-1:0] b, input logic cin,
                                  output logic [BW-1:0] r, output logic [3:0] f);
    longint unsigned u;
    longint s;
    logic c, ov;
    c = 1'b0; ov = 1'b0; r = '0; u = 0; s = 0;
    case (op)
      8'd0: begin
        u = {32'b0, a} + {32'b0, b} + 64'(cin);
        s = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
      end
      8'd1: begin
        u = {32'b0, a} + (64'hFFFF_FFFF - {32'b0, b}) + 64'(cin);
        s = longint'($signed(a)) - longint'($signed(b)) - (64'sd1 - longint'(cin));
      end
      8'd2: u = {32'b0, a & b};
      8'd3: u = {32'b0, a | b};
      8'd4: u = {32'b0, a ^ b};
      default: u = 0;
    endcase
    r = u[31:0];
    if (op == 8'd0 || op == 8'd1) begin
      c  = u[32];
      ov = (s > 64'sd2147483647) || (s < -64'sd2147483648);
    end
    f = {ov, r[31], c, (r == 32'h0)};
  endfunction

  task automatic check_outputs();
    logic [N-1:0] er, ev;
    int g;
    er = '0;
    ev = '0;
    if (rst_n && m_age < 0) begin
      g = pick(v, m_ptr);
      if (g >= 0) er[g] = 1'b1;
    end
    if (m_age == 2) ev[m_owner] = 1'b1;
    chk("req_ready", 64'(req_ready), 64'(er));
    chk("busy", 64'(busy), 64'(m_age > 0));
    chk("rsp_valid", 64'(rsp_valid), 64'(ev));
    chk("rsp_result", 64'(rsp_result), 64'(m_res));
    chk("rsp_flags", 64'(rsp_flags), 64'(m_flags));
    if (m_age == 2)
      $display("txn req=%0d op=%02h a=%08h b=%08h cin=%0d -> result=%08h flags=%b",
               m_owner, m_op, m_a, m_b, m_cin, rsp_result, rsp_flags);
  endtask

  task automatic model_advance();
    int g;
    m_granted = -1;
    if (!rst_n) begin
      m_age = -1; m_ptr = 0; m_owner = 0; m_res = '0; m_flags = '0;
    end else if (m_age < 0) begin
      g = pick(v, m_ptr);
      if (g >= 0) begin
        m_owner = g; m_granted = g; grant_log.push_back(g);
        m_op = t_op[g]; m_a = t_a[g]; m_b = t_b[g]; m_cin = req_cin[g];
        alu_ref(t_op[g], t_a[g], t_b[g], req_cin[g], m_pend_res, m_pend_flags);
        m_age = 1;
      end
    end else if (m_age == 1) begin
      m_res = m_pend_res; m_flags = m_pend_flags; m_age = 2;
    end else begin
      m_ptr = (m_owner + 1) % N; m_age = -1;
    end
  endtask

  // Check mid-cycle, predict the edge, return 1 ns after it.
  task automatic tick();
    @(negedge clk);
    check_outputs();
    model_advance();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input int op, input logic [BW-1:0] a,
                         input logic [BW-1:0] b, input logic cin);
    v[i] = 1'b1; t_op[i] = OW'(op); t_a[i] = a; t_b[i] = b; req_cin[i] = cin;
  endtask

  function automatic logic [BW-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h7FFF_FFFF;
      3: return 32'h8000_0000;
      default: return BW'($urandom);
    endcase
  endfunction

  task automatic rand_req(input int i);
    int op;
    op = ($urandom_range(0, 9) == 0) ? int'($urandom_range(5, 255)) : int'($urandom_range(0, 4));
    set_req(i, op, rand_operand(), rand_operand(), 1'($urandom_range(0, 1)));
  endtask

  task automatic check_log(input string tag, input int exp_q[$]);
    chk({tag, "_count"}, 64'(grant_log.size()), 64'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < grant_log.size(); k++)
      chk(tag, 64'(grant_log[k]), 64'(exp_q[k]));
  endtask

  initial begin
    int rr_exp[$];
    rst_n = 1'b0;
    v = '0; req_cin = '0;
    for (int i = 0; i < N; i++) begin t_op[i] = '0; t_a[i] = '0; t_b[i] = '0; end
    @(posedge clk); #1;
    tick();               // reset state checked with rst_n still low
    rst_n = 1'b1;
    tick();

    // Single request from requester 0.
    set_req(0, ALU_ADD, 32'h80, 32'h80, 1'b0);
    tick();
    v[0] = 1'b0;
    tick();
    chk("single_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("single_result", 64'(rsp_result), 64'h100);
    chk("single_ovf", 64'(rsp_flags[ALU_FLAG_OVERFLOW]), 64'h0);
    tick(); tick();

    // Signed overflow from requester 2.
    set_req(2, ALU_ADD, 32'h7FFF_FFFF, 32'h1, 1'b0);
    tick();
    v[2] = 1'b0;
    tick();
    chk("ovf_rsp_valid", 64'(rsp_valid), 64'h4);
    chk("ovf_result", 64'(rsp_result), 64'h8000_0000);
    chk("ovf_flag", 64'(rsp_flags[ALU_FLAG_OVERFLOW]), 64'h1);
    tick(); tick();

    // Fairness: all four requesting continuously from reset.
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, ALU_SUB, 32'(100 + i), 32'(i), 1'b1);
    tick();
    rst_n = 1'b1;
    grant_log.delete();
    for (int k = 0; k < 24; k++) tick();
    rr_exp = '{0, 1, 2, 3, 0, 1, 2, 3};
    check_log("rr_order", rr_exp);

    // Pointer wrap: after 3 completed, 1 and 3 request together.
    v = '0;
    grant_log.delete();
    set_req(1, ALU_XOR, 32'hAAAA_5555, 32'hFFFF_0000, 1'b0);
    set_req(3, ALU_OR, 32'h0000_00F0, 32'h0000_000F, 1'b0);
    tick();
    v[1] = 1'b0;
    tick(); tick(); tick();
    v[3] = 1'b0;
    tick(); tick();
    rr_exp = '{1, 3};
    check_log("wrap_order", rr_exp);

    // Withdrawn request: 1 asserts during EXEC, drops before IDLE.
    grant_log.delete();
    set_req(0, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 1'b0);
    tick();
    v[0] = 1'b0;
    set_req(1, ALU_ADD, 32'h1234, 32'h1, 1'b0);
    tick();
    v[1] = 1'b0;
    tick(); tick(); tick(); tick();
    rr_exp = '{0};
    check_log("withdraw_order", rr_exp);
    chk("withdraw_result", 64'(rsp_result), 64'h0000_F000);

    // Reset during EXEC drops the op; pointer returns to 0.
    set_req(2, ALU_ADD, 32'h1, 32'h2, 1'b0);
    tick();
    v[2] = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_busy", 64'(busy), 64'h0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_result", 64'(rsp_result), 64'h0);
    chk("rst_flags", 64'(rsp_flags), 64'h0);
    grant_log.delete();
    set_req(0, ALU_ADD, 32'h5, 32'h6, 1'b1);
    set_req(1, ALU_SUB, 32'h5, 32'h6, 1'b1);
    tick();
    v[0] = 1'b0;
    tick(); tick(); tick();
    v[1] = 1'b0;
    tick(); tick();
    rr_exp = '{0, 1};
    check_log("post_rst_order", rr_exp);

    // Randomized traffic with legal withdrawals and occasional resets.
    for (int k = 0; k < 450; k++) begin
      for (int i = 0; i < N; i++) begin
        if (m_granted == i) begin
          if ($urandom_range(0, 1) == 1) rand_req(i);
          else v[i] = 1'b0;
        end else if (v[i]) begin
          if ($urandom_range(0, 15) == 0) v[i] = 1'b0;
        end else if ($urandom_range(0, 2) == 0) begin
          rand_req(i);
        end
      end
      rst_n = ($urandom_range(0, 149) == 0) ? 1'b0 : 1'b1;
      tick();
    end
    rst_n = 1'b1;
    v = '0;
    tick(); tick(); tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
